// File: rtl/mix_seq_ctrl_if.sv
// Control/status bundle for the mixing sequencer: run requests and durations in,
// valve/pump drives and run status out.
interface mix_seq_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] dur_s3;
    logic [CNT_W-1:0] dur_s2;
    logic [CNT_W-1:0] dur_s1;
    logic [CNT_W-1:0] dur_mix;
    logic [CNT_W-1:0] dur_flush;

    logic             valve_s1;
    logic             valve_s2;
    logic             valve_s3;
    logic             valve_out;
    logic             pump_en;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [2:0]       phase;

    // Requester side: issues runs, observes actuators and status.
    modport master (
        output start, abort, dur_s3, dur_s2, dur_s1, dur_mix, dur_flush,
        input  valve_s1, valve_s2, valve_s3, valve_out, pump_en, busy, done, aborted, phase
    );

    // Sequencer side.
    modport slave (
        input  start, abort, dur_s3, dur_s2, dur_s1, dur_mix, dur_flush,
        output valve_s1, valve_s2, valve_s3, valve_out, pump_en, busy, done, aborted, phase
    );
endinterface

// File: rtl/mix_seq_ctrl.sv
// Mixing sequencer: fills soln3, soln2, soln1 in turn, settles, flushes, then pulses
// done (or aborted). Every phase is timed by one shared down-counter.
module mix_seq_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    mix_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLoad3   = 3'd1,
        StLoad2   = 3'd2,
        StLoad1   = 3'd3,
        StMix     = 3'd4,
        StFlush   = 3'd5,
        StFin     = 3'd6,
        StInvalid = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_q, abort_d;
    logic [CNT_W-1:0] dur_s2_q, dur_s2_d;
    logic [CNT_W-1:0] dur_s1_q, dur_s1_d;
    logic [CNT_W-1:0] dur_mix_q, dur_mix_d;
    logic [CNT_W-1:0] dur_flush_q, dur_flush_d;
    logic             cnt_last;

    // A phase of D cycles starts at D-1; zero is stretched to a single cycle.
    function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] dur);
        return (dur == '0) ? '0 : dur - CNT_W'(1);
    endfunction

    assign cnt_last = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            abort_q     <= 1'b0;
            dur_s2_q    <= '0;
            dur_s1_q    <= '0;
            dur_mix_q   <= '0;
            dur_flush_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            abort_q     <= abort_d;
            dur_s2_q    <= dur_s2_d;
            dur_s1_q    <= dur_s1_d;
            dur_mix_q   <= dur_mix_d;
            dur_flush_q <= dur_flush_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        abort_d     = abort_q;
        dur_s2_d    = dur_s2_q;
        dur_s1_d    = dur_s1_q;
        dur_mix_d   = dur_mix_q;
        dur_flush_d = dur_flush_q;

        case (state_q)
            StIdle: begin
                // start beats a simultaneous abort; abort is not looked at here.
                if (bus.start) begin
                    state_d     = StLoad3;
                    cnt_d       = load_val(bus.dur_s3);
                    abort_d     = 1'b0;
                    dur_s2_d    = bus.dur_s2;
                    dur_s1_d    = bus.dur_s1;
                    dur_mix_d   = bus.dur_mix;
                    dur_flush_d = bus.dur_flush;
                end
            end
            StLoad3, StLoad2, StLoad1, StMix: begin
                if (bus.abort) begin
                    state_d = StFlush;
                    cnt_d   = load_val(dur_flush_q);
                    abort_d = 1'b1;
                end else if (!cnt_last) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    unique case (state_q)
                        StLoad3: begin
                            state_d = StLoad2;
                            cnt_d   = load_val(dur_s2_q);
                        end
                        StLoad2: begin
                            state_d = StLoad1;
                            cnt_d   = load_val(dur_s1_q);
                        end
                        StLoad1: begin
                            state_d = StMix;
                            cnt_d   = load_val(dur_mix_q);
                        end
                        default: begin
                            state_d = StFlush;
                            cnt_d   = load_val(dur_flush_q);
                        end
                    endcase
                end
            end
            StFlush: begin
                if (!cnt_last) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
                abort_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                abort_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        bus.valve_s1  = 1'b0;
        bus.valve_s2  = 1'b0;
        bus.valve_s3  = 1'b0;
        bus.valve_out = 1'b0;
        bus.pump_en   = 1'b0;
        bus.done      = 1'b0;
        bus.aborted   = 1'b0;
        bus.busy      = (state_q != StIdle);
        bus.phase     = state_q;

        unique case (state_q)
            StLoad3: begin
                bus.valve_s3 = 1'b1;
                bus.pump_en  = 1'b1;
            end
            StLoad2: begin
                bus.valve_s2 = 1'b1;
                bus.pump_en  = 1'b1;
            end
            StLoad1: begin
                bus.valve_s1 = 1'b1;
                bus.pump_en  = 1'b1;
            end
            StFlush: begin
                bus.valve_out = 1'b1;
                bus.pump_en   = 1'b1;
            end
            StFin: begin
                bus.done    = !abort_q;
                bus.aborted = abort_q;
            end
            default: ;
        endcase
    end

    a_inlet_excl: assert property (@(posedge clk) disable iff (!rst_n)
        $countones({bus.valve_s1, bus.valve_s2, bus.valve_s3}) <= 1);

    a_busy_phase: assert property (@(posedge clk) disable iff (!rst_n)
        bus.busy == (bus.phase != 3'd0));

    // Within a phase the counter only ever moves down.
    a_no_wrap: assert property (@(posedge clk) disable iff (!rst_n)
        (state_d == state_q) |-> (cnt_d <= cnt_q));

endmodule

// File: tb/tb_mix_seq_ctrl.sv
// Randomised bench for mix_seq_ctrl: each run is expanded into a per-cycle list of
// expected phases from the duration rules and every cycle's outputs are compared.
module tb_mix_seq_ctrl;

    localparam int unsigned CNT_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mix_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

    mix_seq_ctrl #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // {phase, busy, s1, s2, s3, out, pump, done, aborted}
    function automatic logic [10:0] outs_for(input logic [2:0] ph, input bit ab);
        logic [10:0] v;
        v       = '0;
        v[10:8] = ph;
        v[7]    = (ph != 3'd0);
        v[6]    = (ph == 3'd3);
        v[5]    = (ph == 3'd2);
        v[4]    = (ph == 3'd1);
        v[3]    = (ph == 3'd5);
        v[2]    = (ph == 3'd1) || (ph == 3'd2) || (ph == 3'd3) || (ph == 3'd5);
        v[1]    = (ph == 3'd6) && !ab;
        v[0]    = (ph == 3'd6) && ab;
        return v;
    endfunction

    function automatic logic [10:0] outs_obs();
        return {bus.phase, bus.busy, bus.valve_s1, bus.valve_s2, bus.valve_s3,
                bus.valve_out, bus.pump_en, bus.done, bus.aborted};
    endfunction

    task automatic check_cycle(input string tag, input logic [2:0] ph, input bit ab);
        check_eq(tag, 32'(outs_obs()), 32'(outs_for(ph, ab)));
        check_eq({tag, "_excl"},
                 32'($countones({bus.valve_s1, bus.valve_s2, bus.valve_s3}) <= 1), 32'd1);
    endtask

    task automatic drive_durs(input int d[5]);
        bus.dur_s3    = CNT_W'(d[0]);
        bus.dur_s2    = CNT_W'(d[1]);
        bus.dur_s1    = CNT_W'(d[2]);
        bus.dur_mix   = CNT_W'(d[3]);
        bus.dur_flush = CNT_W'(d[4]);
    endtask

    task automatic rand_durs();
        int r[5];
        foreach (r[i]) r[i] = int'($urandom_range(0, 20));
        drive_durs(r);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    // Cycle j is the cycle after acceptance edge j. abort_at/restart_at: cycle during
    // which abort/start is held high (-1 = never).
    task automatic run_seq(input string tag, input int d[5], input int abort_at,
                           input int restart_at, input bit chg, input bit start_abort);
        logic [2:0] exp_q[$];
        int         len;
        int         flush_start;
        bit         ab;
        ab = 1'b0;
        for (int p = 0; p < 4; p++) begin
            len = (d[p] == 0) ? 1 : d[p];
            repeat (len) exp_q.push_back(3'(p + 1));
        end
        flush_start = exp_q.size();
        if (abort_at >= 0 && abort_at < flush_start) begin
            while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
            ab = 1'b1;
        end
        len = (d[4] == 0) ? 1 : d[4];
        repeat (len) exp_q.push_back(3'd5);
        exp_q.push_back(3'd6);

        drive_durs(d);
        bus.start = 1'b1;
        bus.abort = start_abort;
        for (int j = 0; j < exp_q.size(); j++) begin
            @(negedge clk);
            check_cycle($sformatf("%s_c%0d", tag, j), exp_q[j], ab);
            bus.start = (j == restart_at);
            bus.abort = (j == abort_at);
            if (chg) rand_durs();
        end
        @(negedge clk);
        check_cycle({tag, "_idle"}, 3'd0, 1'b0);
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    initial begin
        int d[5];
        int tot;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        d = '{0, 0, 0, 0, 0};
        drive_durs(d);

        #1;
        check_eq("reset_outs", 32'(outs_obs()), 32'd0);
        repeat (2) @(negedge clk);
        check_eq("reset_hold", 32'(outs_obs()), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_cycle("post_reset", 3'd0, 1'b0);

        run_seq("nominal", '{3, 2, 4, 5, 2}, -1, -1, 1'b0, 1'b0);
        run_seq("zeros", '{0, 0, 0, 0, 0}, -1, -1, 1'b0, 1'b0);
        run_seq("abort", '{10, 10, 10, 10, 3}, 13, -1, 1'b0, 1'b0);
        run_seq("busy_start", '{3, 2, 4, 5, 2}, -1, 10, 1'b1, 1'b0);
        run_seq("start_abort", '{2, 1, 3, 1, 2}, -1, -1, 1'b0, 1'b1);
        run_seq("abort_flush", '{1, 1, 1, 1, 4}, 5, -1, 1'b0, 1'b0);

        // Reset in the second cycle of LOAD1: outputs must drop without a clock edge.
        d = '{3, 2, 4, 5, 2};
        drive_durs(d);
        bus.start = 1'b1;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check_cycle("rst_pre", 3'd3, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_eq("rst_async", 32'(outs_obs()), 32'd0);
        repeat (2) @(negedge clk);
        check_eq("rst_low", 32'(outs_obs()), 32'd0);
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check_cycle($sformatf("rst_release_c%0d", j), 3'd0, 1'b0);
        end
        run_seq("after_reset", '{1, 2, 1, 2, 1}, -1, -1, 1'b0, 1'b0);

        for (int n = 0; n < 25; n++) begin
            int ab_at;
            int rs_at;
            foreach (d[i]) d[i] = int'($urandom_range(0, 6));
            tot = 0;
            foreach (d[i]) tot += (d[i] == 0) ? 1 : d[i];
            ab_at = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, tot + 1));
            rs_at = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, tot + 1));
            run_seq($sformatf("rnd%0d", n), d, ab_at, rs_at, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
